// File: rtl/bcd_modn_counter.sv
// Parametrised BCD modulo-MOD counter with up/down, clear, range-checked load,
// wrap or saturate at the terminal value, and a combinational tc for cascading stages.
module bcd_modn_counter #(
    parameter int DIGITS = 2,
    parameter int MOD    = 60,
    parameter int WRAP   = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                up,
    input  logic                clr,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    output logic [4*DIGITS-1:0] cnt_num,
    output logic                tc,
    output logic                load_err
);

    localparam int W = 4 * DIGITS;

    function automatic logic [W-1:0] to_bcd(input int value);
        logic [W-1:0] result;
        int           rest;
        result = {W{1'b0}};
        rest   = value;
        for (int k = 0; k < DIGITS; k++) begin
            result[4*k +: 4] = 4'(rest % 10);
            rest             = rest / 10;
        end
        return result;
    endfunction

    function automatic logic bcd_valid(input logic [W-1:0] value);
        logic ok;
        ok = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (value[4*k +: 4] > 4'd9) begin
                ok = 1'b0;
            end else begin
                ok = ok;
            end
        end
        return ok;
    endfunction

    // Terminal value (modulus minus one) in BCD; fits in W bits even at the largest modulus
    localparam logic [W-1:0] LAST_BCD = to_bcd(MOD - 1);

    logic [W-1:0] cnt_r;
    logic         err_r;
    logic [W-1:0] inc_s;
    logic [W-1:0] dec_s;
    logic         at_term_s;
    logic         load_ok_s;

    // Ripple BCD successor and predecessor of the current count
    always_comb begin
        logic carry_v;
        logic borrow_v;
        inc_s    = cnt_r;
        dec_s    = cnt_r;
        carry_v  = 1'b1;
        borrow_v = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (carry_v) begin
                if (cnt_r[4*k +: 4] == 4'd9) begin
                    inc_s[4*k +: 4] = 4'd0;
                    carry_v         = 1'b1;
                end else begin
                    inc_s[4*k +: 4] = cnt_r[4*k +: 4] + 4'd1;
                    carry_v         = 1'b0;
                end
            end else begin
                inc_s[4*k +: 4] = cnt_r[4*k +: 4];
            end
            if (borrow_v) begin
                if (cnt_r[4*k +: 4] == 4'd0) begin
                    dec_s[4*k +: 4] = 4'd9;
                    borrow_v        = 1'b1;
                end else begin
                    dec_s[4*k +: 4] = cnt_r[4*k +: 4] - 4'd1;
                    borrow_v        = 1'b0;
                end
            end else begin
                dec_s[4*k +: 4] = cnt_r[4*k +: 4];
            end
        end
    end

    // Terminal detection, load range check and the cascade output
    always_comb begin
        load_ok_s = bcd_valid(load_val) && (load_val <= LAST_BCD);
        if (up) begin
            at_term_s = (cnt_r == LAST_BCD);
        end else begin
            at_term_s = (cnt_r == {W{1'b0}});
        end
        tc = en & ~clr & ~load & rst_n & at_term_s;
    end

    // Count register and load-reject pulse: clr beats load beats en
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {W{1'b0}};
            err_r <= 1'b0;
        end else if (clr) begin
            cnt_r <= {W{1'b0}};
            err_r <= 1'b0;
        end else if (load) begin
            if (load_ok_s) begin
                cnt_r <= load_val;
                err_r <= 1'b0;
            end else begin
                cnt_r <= cnt_r;
                err_r <= 1'b1;
            end
        end else begin
            err_r <= 1'b0;
            if (!en) begin
                cnt_r <= cnt_r;
            end else if (at_term_s) begin
                if (WRAP != 0) begin
                    cnt_r <= up ? {W{1'b0}} : LAST_BCD;
                end else begin
                    cnt_r <= cnt_r;
                end
            end else begin
                cnt_r <= up ? inc_s : dec_s;
            end
        end
    end

    assign cnt_num  = cnt_r;
    assign load_err = err_r;

endmodule

// File: tb/tb_bcd_modn_counter.sv
// Bench for bcd_modn_counter: a wrapping mod-60, a saturating mod-60 and a mod-24
// stage cascaded from the wrapping one, checked every cycle against integer models.
module tb_bcd_modn_counter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en = 1'b0, up = 1'b1, clr = 1'b0, load = 1'b0, clr_h = 1'b0;
    logic [7:0] load_val = 8'h00;
    logic [7:0] cnt_w, cnt_s, cnt_h;
    logic       tc_w, tc_s, tc_h, err_w, err_s, err_h;

    int n_cmp = 0;
    int n_fail = 0;
    bit chk = 1'b0;
    int m_w = 0, m_s = 0, m_h = 0;
    bit e_w = 1'b0, e_s = 1'b0, e_h = 1'b0;

    always #5 clk = ~clk;

    bcd_modn_counter #(.DIGITS(2), .MOD(60), .WRAP(1)) dut_w (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val), .cnt_num(cnt_w), .tc(tc_w), .load_err(err_w));
    bcd_modn_counter #(.DIGITS(2), .MOD(60), .WRAP(0)) dut_s (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val), .cnt_num(cnt_s), .tc(tc_s), .load_err(err_s));
    bcd_modn_counter #(.DIGITS(2), .MOD(24), .WRAP(1)) dut_h (
        .clk(clk), .rst_n(rst_n), .en(tc_w), .up(up), .clr(clr_h), .load(1'b0),
        .load_val(8'h00), .cnt_num(cnt_h), .tc(tc_h), .load_err(err_h));

    function automatic logic [7:0] bcd(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    function automatic bit load_ok(input logic [7:0] lv, input int mod);
        int hi, lo;
        hi = int'(lv[7:4]);
        lo = int'(lv[3:0]);
        return (hi <= 9) && (lo <= 9) && (hi * 10 + lo < mod);
    endfunction

    function automatic int nxt(input int cur, input int mod, input bit wrap, input logic e,
                               input logic u, input logic c, input logic l, input logic [7:0] lv);
        if (c) return 0;
        if (l) return load_ok(lv, mod) ? int'(lv[7:4]) * 10 + int'(lv[3:0]) : cur;
        if (!e) return cur;
        if (u) return (cur == mod - 1) ? (wrap ? 0 : cur) : cur + 1;
        return (cur == 0) ? (wrap ? mod - 1 : 0) : cur - 1;
    endfunction

    function automatic bit tcm(input int cur, input int mod, input logic e, input logic u,
                               input logic c, input logic l, input logic r);
        return e && !c && !l && r && (u ? (cur == mod - 1) : (cur == 0));
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: integer counts updated on the same edges as the DUTs
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_w <= 0; m_s <= 0; m_h <= 0;
            e_w <= 1'b0; e_s <= 1'b0; e_h <= 1'b0;
        end else begin
            m_w <= nxt(m_w, 60, 1'b1, en, up, clr, load, load_val);
            m_s <= nxt(m_s, 60, 1'b0, en, up, clr, load, load_val);
            m_h <= nxt(m_h, 24, 1'b1, tcm(m_w, 60, en, up, clr, load, 1'b1), up, clr_h, 1'b0, 8'h00);
            e_w <= !clr && load && !load_ok(load_val, 60);
            e_s <= !clr && load && !load_ok(load_val, 60);
            e_h <= 1'b0;
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (chk) begin
            check("cnt_w", cnt_w, bcd(m_w));
            check("cnt_s", cnt_s, bcd(m_s));
            check("cnt_h", cnt_h, bcd(m_h));
            check("tc_w", {7'd0, tc_w}, {7'd0, tcm(m_w, 60, en, up, clr, load, rst_n)});
            check("tc_s", {7'd0, tc_s}, {7'd0, tcm(m_s, 60, en, up, clr, load, rst_n)});
            check("tc_h", {7'd0, tc_h},
                  {7'd0, tcm(m_h, 24, tcm(m_w, 60, en, up, clr, load, rst_n), up, clr_h, 1'b0, rst_n)});
            check("err_w", {7'd0, err_w}, {7'd0, e_w});
            check("err_s", {7'd0, err_s}, {7'd0, e_s});
            check("err_h", {7'd0, err_h}, {7'd0, e_h});
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [7:0] sat_seq [5];
        sat_seq = '{8'h58, 8'h59, 8'h59, 8'h59, 8'h59};

        // Reset, with en/up set so that tc would be high if rst_n were ignored
        en = 1'b1; up = 1'b0;
        #1 rst_n = 1'b0;
        chk = 1'b1;
        #2;
        check("rst_cnt", cnt_w, 8'h00);
        check("rst_tc", {7'd0, tc_w}, 8'h00);
        check("rst_err", {7'd0, err_w}, 8'h00);
        tick(); tick();
        rst_n = 1'b1; up = 1'b1;

        // T1: 60 clocks of up-count wrap
        repeat (59) tick();
        check("t1_59", cnt_w, 8'h59);
        check("t1_tc59", {7'd0, tc_w}, 8'h01);
        tick();
        check("t1_wrap", cnt_w, 8'h00);
        check("t1_tc00", {7'd0, tc_w}, 8'h00);

        // T2: down wrap and ones borrow; saturate stage holds at 0
        load = 1'b1; load_val = 8'h00; up = 1'b0;
        tick();
        load = 1'b0;
        #1;
        check("t2_tc00", {7'd0, tc_w}, 8'h01);
        check("t2_tcs00", {7'd0, tc_s}, 8'h01);
        tick();
        check("t2_59", cnt_w, 8'h59);
        check("t2_sat0", cnt_s, 8'h00);
        tick();
        check("t2_58", cnt_w, 8'h58);
        load = 1'b1; load_val = 8'h50;
        tick();
        load = 1'b0;
        tick();
        check("t2_49", cnt_w, 8'h49);

        // T3: saturate at MOD-1
        up = 1'b1; load = 1'b1; load_val = 8'h57;
        tick();
        load = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t3_cnt", cnt_s, sat_seq[i]);
            check("t3_tc", {7'd0, tc_s}, (i >= 1) ? 8'h01 : 8'h00);
        end

        // T4: load acceptance, rejection and clr priority
        en = 1'b0;
        load = 1'b1; load_val = 8'h42;
        tick();
        check("t4_ld42", cnt_w, 8'h42);
        check("t4_err42", {7'd0, err_w}, 8'h00);
        load_val = 8'h60;
        tick();
        check("t4_hold60", cnt_w, 8'h42);
        check("t4_err60", {7'd0, err_w}, 8'h01);
        load = 1'b0;
        tick();
        check("t4_errclr", {7'd0, err_w}, 8'h00);
        load = 1'b1; load_val = 8'h3A;
        tick();
        check("t4_hold3a", cnt_w, 8'h42);
        check("t4_err3a", {7'd0, err_w}, 8'h01);
        clr = 1'b1;
        tick();
        check("t4_clrld", cnt_w, 8'h00);
        check("t4_clrerr", {7'd0, err_w}, 8'h00);
        clr = 1'b0; load = 1'b0;

        // T5: asynchronous reset mid-count
        en = 1'b1; load = 1'b1; load_val = 8'h36;
        tick();
        load = 1'b0;
        tick();
        check("t5_37", cnt_w, 8'h37);
        #2 rst_n = 1'b0;
        #1;
        check("t5_async", cnt_w, 8'h00);
        check("t5_tc", {7'd0, tc_w}, 8'h00);
        tick();
        rst_n = 1'b1;
        check("t5_held", cnt_w, 8'h00);
        tick();
        check("t5_resume", cnt_w, 8'h01);

        // T6: mod-60 -> mod-24 cascade over a full day-like cycle
        en = 1'b0; clr = 1'b1; clr_h = 1'b1;
        tick();
        clr = 1'b0; clr_h = 1'b0; en = 1'b1; up = 1'b1;
        for (int i = 1; i <= 1440; i++) begin
            tick();
            if (i == 59) check("t6_tcw", {7'd0, tc_w}, 8'h01);
            if (i == 60) check("t6_h01", cnt_h, 8'h01);
            if (i == 1439) check("t6_tch", {7'd0, tc_h}, 8'h01);
        end
        check("t6_w00", cnt_w, 8'h00);
        check("t6_h00", cnt_h, 8'h00);

        chk = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
